// File: rtl/imm_field_packer.sv
// LEGv8 immediate packer: builds B / CBZ / D-type words from a signed
// immediate plus register fields, range-checks the immediate, queues results.
module imm_field_packer #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_fmt,
   input  logic             in_ldst,
   input  logic [63:0]      in_imm,
   input  logic [4:0]       in_rn,
   input  logic [4:0]       in_rt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_word,
   output logic             out_err,
   output logic [CNT_W-1:0] out_count,
   output logic [ERR_W-1:0] err_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [31:0]   word_c;
   logic          err_c;
   logic [32:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic [AW:0]   cnt_n;
   logic          push;
   logic          pop;
   logic [32:0]   head;

   // Pack fields and flag immediates whose upper bits are not a sign extension
   always_comb begin
      word_c = '0;
      err_c  = 1'b0;
      unique case (in_fmt)
         2'b00: begin
            word_c = {6'b000101, in_imm[25:0]};
            err_c  = !((&in_imm[63:25]) || !(|in_imm[63:25]));
         end
         2'b01: begin
            word_c = {8'b10110100, in_imm[18:0], in_rt};
            err_c  = !((&in_imm[63:18]) || !(|in_imm[63:18]));
         end
         2'b10: begin
            word_c = {9'b111110000, in_ldst, 1'b0,
                      in_imm[8:0], 2'b00, in_rn, in_rt};
            err_c  = !((&in_imm[63:8]) || !(|in_imm[63:8]));
         end
         default: begin
            word_c = '0;
            err_c  = 1'b1;
         end
      endcase
   end

   assign push      = in_valid && in_ready;
   assign out_valid = (cnt != '0);
   assign pop       = out_valid && out_ready;
   assign head      = mem[rd_ptr];
   assign out_word  = out_valid ? head[31:0] : '0;
   assign out_err   = out_valid && head[32];

   // Next occupancy; a simultaneous push and pop leaves it unchanged
   always_comb begin
      cnt_n = cnt;
      if (push && !pop)
         cnt_n = cnt + 1'b1;
      else if (!push && pop)
         cnt_n = cnt - 1'b1;
   end

   // FIFO storage, pointers, registered ready and debug counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++)
            mem[k] <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         in_ready  <= 1'b0;
         out_count <= '0;
         err_count <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {err_c, word_c};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            out_count <= out_count + 1'b1;
            if (head[32] && !(&err_count))
               err_count <= err_count + 1'b1;
         end
         cnt      <= cnt_n;
         in_ready <= (cnt_n < FULL);
      end
   end

endmodule

// File: tb/tb_imm_field_packer.sv
// Bench for imm_field_packer: directed vectors plus random traffic
// compared against a queue-based reference of the packing rules.
module tb_imm_field_packer;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_fmt = 2'b00;
   logic        in_ldst = 1'b0;
   logic [63:0] in_imm = '0;
   logic [4:0]  in_rn = '0;
   logic [4:0]  in_rt = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_word;
   logic        out_err;
   logic [15:0] out_count;
   logic [7:0]  err_count;

   imm_field_packer #(.DEPTH(DEPTH), .CNT_W(16), .ERR_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_ldst(in_ldst), .in_imm(in_imm),
      .in_rn(in_rn), .in_rt(in_rt),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_word(out_word), .out_err(out_err),
      .out_count(out_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_err = 0;
   logic [32:0] q[$];
   bit          m_ready = 0;
   int          m_cnt = 0;
   int          m_ecnt = 0;
   bit          last_push = 0;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: field width W fits iff -2^(W-1) <= imm < 2^(W-1)
   function automatic logic [32:0] ref_pack(logic [1:0] f, logic ld,
                                            longint imm, logic [4:0] rn,
                                            logic [4:0] rt);
      longint lim;
      logic [63:0] w;
      logic [63:0] u;
      u = imm;
      case (f)
         2'd0: begin
            lim = 64'sd1 <<< 25;
            w = (64'd5 << 26) | (u & ((64'd1 << 26) - 1));
         end
         2'd1: begin
            lim = 64'sd1 <<< 18;
            w = (64'hB4 << 24) | ((u & ((64'd1 << 19) - 1)) << 5) | 64'(rt);
         end
         2'd2: begin
            lim = 64'sd1 <<< 8;
            w = ((ld ? 64'h7C2 : 64'h7C0) << 21) | ((u & 64'h1FF) << 12)
                | (64'(rn) << 5) | 64'(rt);
         end
         default: return {1'b1, 32'h0};
      endcase
      return {!(imm >= -lim && imm < lim), w[31:0]};
   endfunction

   task automatic check_all(string tag);
      chk({tag, "_rdy"}, 64'(in_ready), 64'(m_ready));
      chk({tag, "_vld"}, 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         chk({tag, "_word"}, 64'(out_word), 64'(q[0][31:0]));
         chk({tag, "_err"}, 64'(out_err), 64'(q[0][32]));
      end else begin
         chk({tag, "_word0"}, 64'(out_word), 64'd0);
      end
      chk({tag, "_ocnt"}, 64'(out_count), 64'(m_cnt[15:0]));
      chk({tag, "_ecnt"}, 64'(err_count), 64'(m_ecnt));
   endtask

   task automatic step(string tag);
      bit pu;
      bit po;
      logic [32:0] e;
      pu = rst_n && in_valid && m_ready;
      po = rst_n && out_ready && (q.size() != 0);
      e = ref_pack(in_fmt, in_ldst, longint'(in_imm), in_rn, in_rt);
      @(posedge clk);
      #1;
      if (rst_n) begin
         if (po) begin
            if (q[0][32] && m_ecnt < 255) m_ecnt++;
            m_cnt++;
            void'(q.pop_front());
         end
         if (pu) q.push_back(e);
         m_ready = (q.size() < DEPTH);
      end
      last_push = pu;
      check_all(tag);
   endtask

   task automatic drive(logic [1:0] f, logic ld, logic [63:0] imm,
                        logic [4:0] rn, logic [4:0] rt);
      in_valid = 1'b1;
      in_fmt = f;
      in_ldst = ld;
      in_imm = imm;
      in_rn = rn;
      in_rt = rt;
   endtask

   task automatic drive_rand();
      longint r;
      r = {$urandom, $urandom};
      r = r >>> $urandom_range(0, 63);
      drive(2'($urandom_range(0, 3)), 1'($urandom), r,
            5'($urandom), 5'($urandom));
   endtask

   initial begin
      int base;
      // reset state
      @(posedge clk);
      #1;
      chk("rst_rdy", 64'(in_ready), 64'd0);
      chk("rst_vld", 64'(out_valid), 64'd0);
      chk("rst_word", 64'(out_word), 64'd0);
      chk("rst_err", 64'(out_err), 64'd0);
      chk("rst_ocnt", 64'(out_count), 64'd0);
      chk("rst_ecnt", 64'(err_count), 64'd0);
      rst_n = 1'b1;
      step("rel");
      chk("rel_rdy1", 64'(in_ready), 64'd1);

      // B, imm = -1
      drive(2'd0, 1'b0, -64'sd1, 5'd0, 5'd0);
      step("b");
      in_valid = 1'b0;
      chk("b_m1_vld", 64'(out_valid), 64'd1);
      chk("b_m1_word", 64'(out_word), 64'h17FFFFFF);
      chk("b_m1_err", 64'(out_err), 64'd0);
      out_ready = 1'b1;
      step("b_pop");
      out_ready = 1'b0;

      // CBZ then LDUR
      drive(2'd1, 1'b0, 64'd4, 5'd0, 5'd3);
      step("cbz");
      chk("cbz_word", 64'(out_word), 64'hB4000083);
      drive(2'd2, 1'b1, -64'sd2, 5'd2, 5'd1);
      step("ldur");
      in_valid = 1'b0;
      chk("ldur_hold", 64'(out_word), 64'hB4000083);
      out_ready = 1'b1;
      step("cbz_pop");
      chk("ldur_word", 64'(out_word), 64'hF85FE041);
      chk("ldur_err", 64'(out_err), 64'd0);
      step("ldur_pop");
      out_ready = 1'b0;

      // STUR overflow and illegal format
      drive(2'd2, 1'b0, 64'd256, 5'd0, 5'd0);
      step("stur");
      in_valid = 1'b0;
      chk("stur_word", 64'(out_word), 64'hF8100000);
      chk("stur_err", 64'(out_err), 64'd1);
      out_ready = 1'b1;
      step("stur_pop");
      out_ready = 1'b0;
      drive(2'd3, 1'b0, 64'd12345, 5'd7, 5'd9);
      step("ill");
      in_valid = 1'b0;
      chk("ill_word", 64'(out_word), 64'd0);
      chk("ill_err", 64'(out_err), 64'd1);
      out_ready = 1'b1;
      step("ill_pop");
      out_ready = 1'b0;
      chk("ecnt2", 64'(err_count), 64'd2);
      chk("ocnt5", 64'(out_count), 64'd5);

      // range boundaries
      drive(2'd0, 1'b0, (64'd1 << 25) - 1, 5'd0, 5'd0);
      step("bmax");
      chk("bmax_err", 64'(out_err), 64'd0);
      drive(2'd0, 1'b0, 64'd1 << 25, 5'd0, 5'd0);
      out_ready = 1'b1;
      step("bover");
      chk("bover_err", 64'(out_err), 64'd1);
      drive(2'd1, 1'b0, -(64'sd1 <<< 18), 5'd0, 5'd31);
      step("cmin");
      chk("cmin_err", 64'(out_err), 64'd0);
      drive(2'd2, 1'b1, -64'sd257, 5'd1, 5'd1);
      step("dunder");
      chk("dunder_err", 64'(out_err), 64'd1);
      in_valid = 1'b0;
      step("bnd_pop");
      out_ready = 1'b0;

      // backpressure: third push waits until a pop frees space
      base = m_cnt;
      drive(2'd1, 1'b0, 64'd1, 5'd0, 5'd1);
      step("bp1");
      drive(2'd1, 1'b0, 64'd2, 5'd0, 5'd2);
      step("bp2");
      chk("bp_full_rdy", 64'(in_ready), 64'd0);
      drive(2'd1, 1'b0, 64'd3, 5'd0, 5'd3);
      step("bp3a");
      step("bp3b");
      chk("bp3_held", 64'(last_push), 64'd0);
      out_ready = 1'b1;
      last_push = 0;
      for (int k = 0; k < 8 && !last_push; k++) step("bp3w");
      chk("bp3_accept", 64'(last_push), 64'd1);
      in_valid = 1'b0;
      for (int k = 0; k < 8 && q.size() != 0; k++) step("bp_drain");
      chk("bp_count3", 64'(out_count), 64'(base + 3));

      // back-to-back with constant out_ready
      for (int k = 0; k < 8; k++) begin
         drive_rand();
         step("b2b");
         chk("b2b_acc", 64'(last_push), 64'd1);
      end
      in_valid = 1'b0;
      step("b2b_end");

      // random traffic
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 3) != 0) drive_rand();
         else in_valid = 1'b0;
         out_ready = ($urandom_range(0, 2) != 0);
         step("rnd");
      end

      // mid-stream reset with two entries queued
      out_ready = 1'b0;
      in_valid = 1'b0;
      for (int k = 0; k < 8 && q.size() != 0; k++) begin
         out_ready = 1'b1;
         step("pre_drain");
      end
      out_ready = 1'b0;
      drive(2'd0, 1'b0, 64'd77, 5'd0, 5'd0);
      step("mr1");
      drive(2'd0, 1'b0, 64'd78, 5'd0, 5'd0);
      step("mr2");
      in_valid = 1'b0;
      chk("mr_full", 64'(q.size()), 64'd2);
      rst_n = 1'b0;
      q.delete();
      m_ready = 0;
      m_cnt = 0;
      m_ecnt = 0;
      #1;
      check_all("mrst");
      step("mrst_hold");
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) step("mrst_after");
      chk("mrst_vld", 64'(out_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
